// File: rtl/reg_file_8x16.sv
// rtl/reg_file_8x16.sv - 8-entry register file with pending-write scoreboard, hazard stall and sticky wordline error
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_8x16 #(
  parameter int DATA_WIDTH = 16,
  parameter bit R0_ZERO    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            Wordline,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [2:0]            SrcReg1,
  input  logic [2:0]            SrcReg2,
  output logic [DATA_WIDTH-1:0] SrcData1,
  output logic [DATA_WIDTH-1:0] SrcData2,
  input  logic                  Reserve,
  input  logic [2:0]            DstReg,
  input  logic                  Src1Used,
  input  logic                  Src2Used,
  output logic                  Stall,
  output logic [7:0]            BusyVec,
  output logic                  WordlineErr
);

  logic [DATA_WIDTH-1:0] regs [8];
  logic [7:0]            busy;
  logic                  err;

  logic       wl_illegal;
  logic [7:0] wr_mask;
  logic [7:0] rsv_mask;
  logic [7:0] keep_mask;
  logic       fwd1;
  logic       fwd2;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign wl_illegal = (Wordline & (Wordline - 8'd1)) != 8'd0;
  assign wr_mask    = wl_illegal ? 8'd0 : Wordline;
  assign keep_mask  = R0_ZERO ? 8'hFE : 8'hFF;
  assign rsv_mask   = Reserve ? (8'd1 << DstReg) : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      busy <= 8'd0;
      err  <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_mask[i] && keep_mask[i]) regs[i] <= WriteData;
      end
      // Reserve applied after release so the newer instruction keeps ownership.
      busy <= ((busy & ~wr_mask) | rsv_mask) & keep_mask;
      if (wl_illegal) err <= 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wr_mask[SrcReg1];
  assign fwd2 = wr_mask[SrcReg2];
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign SrcData1 = (R0_ZERO && SrcReg1 == 3'd0) ? '0 :
                    fwd1 ? WriteData : regs[SrcReg1];
  assign SrcData2 = (R0_ZERO && SrcReg2 == 3'd0) ? '0 :
                    fwd2 ? WriteData : regs[SrcReg2];

  // A forwarded operand is supplied now, so its busy bit cannot hold decode.
  assign Stall = (Src1Used & busy[SrcReg1] & ~fwd1) |
                 (Src2Used & busy[SrcReg2] & ~fwd2);

  assign BusyVec     = busy;
  assign WordlineErr = err;

endmodule

// File: tb/tb_reg_file_8x16.sv
// tb/tb_reg_file_8x16.sv - scoreboard bench for reg_file_8x16 (R0_ZERO = 0 and 1 instances)
module tb_reg_file_8x16;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  wl;
  logic [15:0] wd;
  logic [2:0]  s1, s2, dst;
  logic        res, u1, u2;

  logic [15:0] a_d1, a_d2, b_d1, b_d2;
  logic        a_st, b_st, a_err, b_err;
  logic [7:0]  a_bv, b_bv;

  reg_file_8x16 #(.DATA_WIDTH(16), .R0_ZERO(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .Wordline(wl), .WriteData(wd),
    .SrcReg1(s1), .SrcReg2(s2), .SrcData1(a_d1), .SrcData2(a_d2),
    .Reserve(res), .DstReg(dst), .Src1Used(u1), .Src2Used(u2),
    .Stall(a_st), .BusyVec(a_bv), .WordlineErr(a_err)
  );

  reg_file_8x16 #(.DATA_WIDTH(16), .R0_ZERO(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .Wordline(wl), .WriteData(wd),
    .SrcReg1(s1), .SrcReg2(s2), .SrcData1(b_d1), .SrcData2(b_d2),
    .Reserve(res), .DstReg(dst), .Src1Used(u1), .Src2Used(u2),
    .Stall(b_st), .BusyVec(b_bv), .WordlineErr(b_err)
  );

  typedef struct {
    int          k;
    int          step;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        st;
    logic [7:0]  bv;
    logic        err;
  } exp_t;

  exp_t q[$];

  // Reference state: index 0 models R0_ZERO=0, index 1 models R0_ZERO=1.
  logic [15:0] mem  [2][8];
  logic        busy [2][8];
  logic        err_m[2];

  int tests = 0;
  int fails = 0;
  int step_no = 0;

  function automatic bit wl_onehot();
    return $countones(wl) == 1;
  endfunction

  function automatic logic [15:0] mread(int k, logic [2:0] s);
    if (k == 1 && s == 3'd0) return 16'h0000;
    if (BYP && wl_onehot() && wl[s]) return wd;
    return mem[k][s];
  endfunction

  function automatic logic mbusy(int k, logic [2:0] s);
    return busy[k][s] && !(BYP && wl_onehot() && wl[s]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        mem[k][i]  = 16'h0000;
        busy[k][i] = 1'b0;
      end
      err_m[k] = 1'b0;
    end
  endtask

  // Apply the edge that just happened using the inputs that were held across it.
  task automatic model_commit();
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (wl_onehot()) begin
          for (int i = 0; i < 8; i++) begin
            if (wl[i]) begin
              if (!(k == 1 && i == 0)) mem[k][i] = wd;
              busy[k][i] = 1'b0;
            end
          end
        end else if (wl != 8'd0) begin
          err_m[k] = 1'b1;
        end
        if (res && !(k == 1 && dst == 3'd0)) busy[k][dst] = 1'b1;
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.k    = k;
      e.step = step_no;
      e.d1   = mread(k, s1);
      e.d2   = mread(k, s2);
      e.st   = (u1 && mbusy(k, s1)) || (u2 && mbusy(k, s2));
      for (int i = 0; i < 8; i++) e.bv[i] = busy[k][i];
      e.err  = err_m[k];
      q.push_back(e);
    end
  endtask

  task automatic step(input logic rn, input logic [7:0] w, input logic [15:0] d,
                      input logic [2:0] r1, input logic [2:0] r2,
                      input logic rv, input logic [2:0] ds,
                      input logic v1, input logic v2);
    @(posedge clk);
    #1;
    model_commit();
    rst_n = rn; wl = w; wd = d; s1 = r1; s2 = r2;
    res = rv; dst = ds; u1 = v1; u2 = v2;
    if (!rn) model_reset();
    step_no++;
    push_expect();
  endtask

  task automatic check(input string name, input int k, input int sn,
                       input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s inst%0d step%0d actual=%h required=%h", name, k, sn, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.k == 0) begin
        check("d1",      0, e.step, a_d1, e.d1);
        check("d2",      0, e.step, a_d2, e.d2);
        check("stall",   0, e.step, {15'd0, a_st}, {15'd0, e.st});
        check("busyvec", 0, e.step, {8'd0, a_bv}, {8'd0, e.bv});
        check("err",     0, e.step, {15'd0, a_err}, {15'd0, e.err});
      end else begin
        check("d1",      1, e.step, b_d1, e.d1);
        check("d2",      1, e.step, b_d2, e.d2);
        check("stall",   1, e.step, {15'd0, b_st}, {15'd0, e.st});
        check("busyvec", 1, e.step, {8'd0, b_bv}, {8'd0, e.bv});
        check("err",     1, e.step, {15'd0, b_err}, {15'd0, e.err});
      end
    end
  end

  initial begin
    logic [7:0] w;
    int         a;
    rst_n = 1'b0; wl = 8'd0; wd = 16'd0; s1 = 3'd0; s2 = 3'd0;
    res = 1'b0; dst = 3'd0; u1 = 1'b0; u2 = 1'b0;
    model_reset();

    step(1'b0, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Async reset mid-cycle after a write and a reservation.
    step(1'b1, 8'h08, 16'hBEEF, 3'd3, 3'd5, 1'b1, 3'd5, 1'b1, 1'b1);
    step(1'b1, 8'h00, 16'h0000, 3'd3, 3'd5, 1'b0, 3'd0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 16'h0000, 3'd3, 3'd5, 1'b0, 3'd0, 1'b1, 1'b1);
    step(1'b1, 8'h00, 16'h0000, 3'd3, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0);

    // Write r4, read in the same cycle and the next.
    step(1'b1, 8'h10, 16'h1234, 3'd4, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 8'h00, 16'h5555, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);

    // RAW hazard on r2 released by writeback.
    step(1'b1, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0);
    step(1'b1, 8'h00, 16'h0000, 3'd0, 3'd2, 1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 8'h04, 16'h2222, 3'd0, 3'd2, 1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 8'h00, 16'h0000, 3'd0, 3'd2, 1'b0, 3'd0, 1'b0, 1'b1);

    // Simultaneous release and reserve of r1.
    step(1'b1, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0);
    step(1'b1, 8'h02, 16'h1111, 3'd1, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0);
    step(1'b1, 8'h00, 16'h0000, 3'd1, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);

    // Illegal wordline with r1 and r3 busy, then a legal write.
    step(1'b1, 8'h00, 16'h0000, 3'd1, 3'd3, 1'b1, 3'd3, 1'b0, 1'b0);
    step(1'b1, 8'h0A, 16'hFFFF, 3'd1, 3'd3, 1'b0, 3'd0, 1'b1, 1'b1);
    step(1'b1, 8'h40, 16'h6666, 3'd1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 8'h00, 16'h0000, 3'd6, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0);

    // Register 0 writes and reservations after a fresh reset.
    step(1'b0, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 8'h01, 16'hAAAA, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    step(1'b1, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1);

    for (int n = 0; n < 600; n++) begin
      a = int'($urandom_range(0, 9));
      if (a < 3) w = 8'd0;
      else if (a < 9) w = 8'd1 << $urandom_range(0, 7);
      else begin
        a = int'($urandom_range(0, 7));
        w = 8'($urandom) | (8'd1 << a) | (8'd1 << ((a + 1) % 8));
      end
      step(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1, w, 16'($urandom),
           3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    check("drain", 0, step_no, 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
